// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types, defaults and round-robin helper for the phase controller
package traffic_pkg;

  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW, FLASH} state_t;

  localparam int MAX_PHASES    = 8;
  localparam int PHASE_W_MAX   = $clog2(MAX_PHASES);

  localparam int DEF_GREEN_CYC  = 30000000;
  localparam int DEF_YELLOW_CYC = 5000000;
  localparam int DEF_ALLRED_CYC = 2000000;
  localparam int DEF_FLASH_CYC  = 10000000;

  // First pending index after base (wrapping, base itself checked last); -1 if none.
  function automatic int next_pending_phase(input logic [MAX_PHASES-1:0] pend,
                                            input int base, input int n);
    int idx;
    next_pending_phase = -1;
    for (int i = MAX_PHASES; i >= 1; i--) begin
      if (i <= n) begin
        idx = (base + i) % n;
        if (pend[PHASE_W_MAX'(idx)]) next_pending_phase = idx;
      end
    end
  endfunction

endpackage

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - loadable down-counter that parks at zero
module interval_timer #(
  parameter int               CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)           cnt <= RESET_VAL;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - multi-phase round-robin signal controller with all-red clearance and flash mode
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int GREEN_CYC  = DEF_GREEN_CYC,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC = DEF_ALLRED_CYC,
  parameter int FLASH_CYC  = DEF_FLASH_CYC,
  parameter int CNT_W      = 32,
  localparam int PW        = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PHASES-1:0] req,
  input  logic                  flash_mode,
  output logic [NUM_PHASES-1:0] red,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] green,
  output logic [PW-1:0]         active_phase,
  output logic                  phase_start,
  output logic                  in_flash
);

  state_t                  state, nstate;
  logic [NUM_PHASES-1:0]   pending, sel;
  logic                    tog, fresh;
  logic                    tload, tzero, enter_green, pulse, tog_flip, other_pending;
  logic [CNT_W-1:0]        tval;
  logic [PW-1:0]           gphase;
  logic [MAX_PHASES-1:0]   pend_ext;
  int                      nxt;

  interval_timer #(.CNT_W(CNT_W), .RESET_VAL(CNT_W'(ALLRED_CYC - 1))) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tload),
    .load_val (tval),
    .zero     (tzero)
  );

  assign sel           = NUM_PHASES'(1) << active_phase;
  assign other_pending = |(pending & ~sel);
  assign pend_ext      = MAX_PHASES'(pending);
  // Straight after reset the scan starts from the top so phase 0 is served first.
  assign nxt = next_pending_phase(pend_ext, fresh ? NUM_PHASES - 1 : int'(active_phase), NUM_PHASES);

  always_comb begin
    nstate      = state;
    tload       = 1'b0;
    tval        = '0;
    enter_green = 1'b0;
    gphase      = active_phase;
    pulse       = 1'b0;
    tog_flip    = 1'b0;
    case (state)
      ALLRED: if (tzero) begin
        tload = 1'b1;
        if (flash_mode) begin
          nstate = FLASH;
          tval   = CNT_W'(FLASH_CYC - 1);
        end else begin
          nstate      = GREEN;
          tval        = CNT_W'(GREEN_CYC - 1);
          enter_green = 1'b1;
          if (nxt >= 0) begin
            gphase = PW'(nxt);
            pulse  = 1'b1;
          end
        end
      end
      GREEN: if (flash_mode || (tzero && other_pending)) begin
        nstate = YELLOW;
        tload  = 1'b1;
        tval   = CNT_W'(YELLOW_CYC - 1);
      end
      YELLOW: if (tzero) begin
        nstate = ALLRED;
        tload  = 1'b1;
        tval   = CNT_W'(ALLRED_CYC - 1);
      end
      FLASH: begin
        if (!flash_mode) begin
          nstate = ALLRED;
          tload  = 1'b1;
          tval   = CNT_W'(ALLRED_CYC - 1);
        end else if (tzero) begin
          tload    = 1'b1;
          tval     = CNT_W'(FLASH_CYC - 1);
          tog_flip = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ALLRED;
      active_phase <= '0;
      pending      <= '1;
      tog          <= 1'b1;
      fresh        <= 1'b1;
      phase_start  <= 1'b0;
    end else begin
      state        <= nstate;
      active_phase <= gphase;
      phase_start  <= pulse;
      // Clear beats a same-cycle request so demand must reappear after green entry.
      pending      <= (pending | req) & ~(enter_green ? (NUM_PHASES'(1) << gphase) : '0);
      if (nstate == FLASH && state != FLASH) tog <= 1'b1;
      else if (tog_flip)                     tog <= ~tog;
      if (enter_green) fresh <= 1'b0;
    end
  end

  always_comb begin
    red    = '1;
    yellow = '0;
    green  = '0;
    case (state)
      GREEN:  begin green  = sel; red = ~sel; end
      YELLOW: begin yellow = sel; red = ~sel; end
      FLASH:  red = {NUM_PHASES{tog}};
      default: ;
    endcase
  end

  assign in_flash = (state == FLASH);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - table-driven check of phase rotation, rest, re-latch, flash and reset
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = '0;
  logic       flash_mode = 1'b0;
  logic [2:0] red, yellow, green;
  logic [1:0] active_phase;
  logic       phase_start, in_flash;

  int checks = 0;
  int errors = 0;
  logic inv_on = 1'b0;

  traffic_phase_ctrl #(
    .NUM_PHASES(3), .GREEN_CYC(8), .YELLOW_CYC(3), .ALLRED_CYC(2), .FLASH_CYC(4), .CNT_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .flash_mode   (flash_mode),
    .red          (red),
    .yellow       (yellow),
    .green        (green),
    .active_phase (active_phase),
    .phase_start  (phase_start),
    .in_flash     (in_flash)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] rq;
    logic       fl;
    int         n;
    logic [2:0] r, y, g;
    logic       st;
    logic       inf;
    logic [1:0] ap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [2:0] rq, input logic fl, input int n,
                              input logic [2:0] r, input logic [2:0] y, input logic [2:0] g,
                              input logic st, input logic inf, input logic [1:0] ap);
    vec_t v;
    v.rst = rst; v.rq = rq; v.fl = fl; v.n = n;
    v.r = r; v.y = y; v.g = g; v.st = st; v.inf = inf; v.ap = ap;
    return v;
  endfunction

  task automatic cmp(input string name, input int seg, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s seg %0d cyc %0d: got %0h expected %0h", name, seg, cyc, act, exp);
    end
  endtask

  task automatic check_all(input int seg, input int cyc, input logic [2:0] r, input logic [2:0] y,
                           input logic [2:0] g, input logic st, input logic inf, input logic [1:0] ap);
    cmp("red", seg, cyc, red, r);
    cmp("yellow", seg, cyc, yellow, y);
    cmp("green", seg, cyc, green, g);
    cmp("phase_start", seg, cyc, phase_start, st);
    cmp("in_flash", seg, cyc, in_flash, inf);
    cmp("active_phase", seg, cyc, active_phase, ap);
  endtask

  task automatic step(input logic rst, input logic [2:0] rq, input logic fl);
    reset = rst; req = rq; flash_mode = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Lamp safety invariant, checked every cycle outside flash.
  always @(negedge clk) begin
    if (inv_on && !in_flash) begin
      checks++;
      for (int i = 0; i < 3; i++) begin
        if ((32'(red[i]) + 32'(yellow[i]) + 32'(green[i])) != 1) begin
          errors++;
          $display("FAIL lamp_onehot phase %0d: r%b y%b g%b expected exactly one lamp", i, red[i], yellow[i], green[i]);
        end
      end
      if ($countones(yellow | green) > 1) begin
        errors++;
        $display("FAIL conflict: yellow|green=%b expected at most one bit", yellow | green);
      end
    end
  end

  initial begin
    //                 rst rq      fl  n  red     yel     grn    st  inf ap
    tbl.push_back(mk(1, 3'b000, 0, 2, 3'b111, 3'b000, 3'b000, 0, 0, 0)); // 0 reset
    tbl.push_back(mk(0, 3'b000, 0, 1, 3'b111, 3'b000, 3'b000, 0, 0, 0)); // 1 allred 2nd
    tbl.push_back(mk(0, 3'b000, 0, 8, 3'b110, 3'b000, 3'b001, 1, 0, 0)); // 2 ph0 green
    tbl.push_back(mk(0, 3'b000, 0, 3, 3'b110, 3'b001, 3'b000, 0, 0, 0)); // 3
    tbl.push_back(mk(0, 3'b000, 0, 2, 3'b111, 3'b000, 3'b000, 0, 0, 0)); // 4
    tbl.push_back(mk(0, 3'b000, 0, 8, 3'b101, 3'b000, 3'b010, 1, 0, 1)); // 5 ph1 green
    tbl.push_back(mk(0, 3'b000, 0, 3, 3'b101, 3'b010, 3'b000, 0, 0, 1)); // 6
    tbl.push_back(mk(0, 3'b000, 0, 2, 3'b111, 3'b000, 3'b000, 0, 0, 1)); // 7
    tbl.push_back(mk(0, 3'b000, 0, 8, 3'b011, 3'b000, 3'b100, 1, 0, 2)); // 8 ph2 green
    tbl.push_back(mk(0, 3'b000, 0, 6, 3'b011, 3'b000, 3'b100, 0, 0, 2)); // 9 rest
    tbl.push_back(mk(0, 3'b010, 0, 1, 3'b011, 3'b000, 3'b100, 0, 0, 2)); // 10 req1 pulse
    tbl.push_back(mk(0, 3'b000, 0, 3, 3'b011, 3'b100, 3'b000, 0, 0, 2)); // 11
    tbl.push_back(mk(0, 3'b000, 0, 2, 3'b111, 3'b000, 3'b000, 0, 0, 2)); // 12
    tbl.push_back(mk(0, 3'b000, 0, 8, 3'b101, 3'b000, 3'b010, 1, 0, 1)); // 13 ph0 skipped
    tbl.push_back(mk(0, 3'b000, 0, 2, 3'b101, 3'b000, 3'b010, 0, 0, 1)); // 14 rest
    tbl.push_back(mk(0, 3'b001, 0, 1, 3'b101, 3'b000, 3'b010, 0, 0, 1)); // 15 req0 held
    tbl.push_back(mk(0, 3'b001, 0, 3, 3'b101, 3'b010, 3'b000, 0, 0, 1)); // 16
    tbl.push_back(mk(0, 3'b001, 0, 2, 3'b111, 3'b000, 3'b000, 0, 0, 1)); // 17
    tbl.push_back(mk(0, 3'b001, 0, 2, 3'b110, 3'b000, 3'b001, 1, 0, 0)); // 18 entry with req0 high
    tbl.push_back(mk(0, 3'b000, 0, 6, 3'b110, 3'b000, 3'b001, 0, 0, 0)); // 19
    tbl.push_back(mk(0, 3'b000, 0, 2, 3'b110, 3'b000, 3'b001, 0, 0, 0)); // 20 rest
    tbl.push_back(mk(0, 3'b010, 0, 1, 3'b110, 3'b000, 3'b001, 0, 0, 0)); // 21 req1 pulse
    tbl.push_back(mk(0, 3'b000, 0, 3, 3'b110, 3'b001, 3'b000, 0, 0, 0)); // 22
    tbl.push_back(mk(0, 3'b000, 0, 2, 3'b111, 3'b000, 3'b000, 0, 0, 0)); // 23
    tbl.push_back(mk(0, 3'b000, 0, 3, 3'b101, 3'b000, 3'b010, 1, 0, 1)); // 24 ph1 green cyc 1..3
    tbl.push_back(mk(0, 3'b000, 1, 3, 3'b101, 3'b010, 3'b000, 0, 0, 1)); // 25 flash cuts green
    tbl.push_back(mk(0, 3'b000, 1, 2, 3'b111, 3'b000, 3'b000, 0, 0, 1)); // 26
    tbl.push_back(mk(0, 3'b000, 1, 4, 3'b111, 3'b000, 3'b000, 0, 1, 1)); // 27 flash on
    tbl.push_back(mk(0, 3'b000, 1, 4, 3'b000, 3'b000, 3'b000, 0, 1, 1)); // 28 flash off
    tbl.push_back(mk(0, 3'b000, 1, 4, 3'b111, 3'b000, 3'b000, 0, 1, 1)); // 29
    tbl.push_back(mk(0, 3'b000, 1, 2, 3'b000, 3'b000, 3'b000, 0, 1, 1)); // 30
    tbl.push_back(mk(0, 3'b000, 0, 2, 3'b111, 3'b000, 3'b000, 0, 0, 1)); // 31 flash exit
    tbl.push_back(mk(0, 3'b000, 0, 8, 3'b110, 3'b000, 3'b001, 1, 0, 0)); // 32 relatched ph0
    tbl.push_back(mk(0, 3'b000, 0, 2, 3'b110, 3'b000, 3'b001, 0, 0, 0)); // 33 rest

    for (int s = 0; s < tbl.size(); s++) begin
      for (int c = 0; c < tbl[s].n; c++) begin
        step(tbl[s].rst, tbl[s].rq, tbl[s].fl);
        inv_on = 1'b1;
        check_all(s, c, tbl[s].r, tbl[s].y, tbl[s].g, (c == 0) ? tbl[s].st : 1'b0, tbl[s].inf, tbl[s].ap);
      end
    end

    // Reset asserted in the middle of a yellow interval.
    step(0, 3'b100, 0);
    check_all(100, 0, 3'b110, 3'b000, 3'b001, 0, 0, 0);
    step(0, 3'b000, 0);
    check_all(100, 1, 3'b110, 3'b001, 3'b000, 0, 0, 0);
    step(1, 3'b000, 0);
    check_all(100, 2, 3'b111, 3'b000, 3'b000, 0, 0, 0);
    step(0, 3'b000, 0);
    check_all(100, 3, 3'b111, 3'b000, 3'b000, 0, 0, 0);
    step(0, 3'b000, 0);
    check_all(100, 4, 3'b110, 3'b000, 3'b001, 1, 0, 0);
    step(0, 3'b000, 0);
    check_all(100, 5, 3'b110, 3'b000, 3'b001, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
